// File: rtl/uint_fp_stream_converter_n_if.sv
// -----------------------------------------------------------------------------
// uint_fp_stream_converter_n_if
// Stream bundle for the multi-channel unsigned-integer to floating-point
// converter. It carries the input pixel stream (uint/col/row/valid with
// ready back to the source) and the converted output stream (fp/col/row/
// valid/sof/eof with ready from the sink).
//
//   slave  : converter side (consumes uint stream, produces fp stream)
//   master : environment side (source of uint stream, sink of fp stream)
//
// Signals
//   uint_i   CHANNELS x UINT_WIDTH  input pixels, one per channel
//   col_i    COORD_WIDTH            input column
//   row_i    COORD_WIDTH            input row
//   valid_i  1                      input beat valid
//   ready_o  1                      converter accepts input this cycle
//   fp_o     CHANNELS x FP_WIDTH    converted pixels
//   col_o    COORD_WIDTH            column aligned with fp_o
//   row_o    COORD_WIDTH            row aligned with fp_o
//   valid_o  1                      output beat valid
//   ready_i  1                      sink accepts output beat
//   sof_o    1                      output beat is (0,0)
//   eof_o    1                      output beat is the last pixel of a frame
// -----------------------------------------------------------------------------
interface uint_fp_stream_converter_n_if #(
   parameter int CHANNELS    = 2,
   parameter int UINT_WIDTH  = 8,
   parameter int FP_WIDTH    = 16,
   parameter int COORD_WIDTH = 16
);
   logic [CHANNELS-1:0][UINT_WIDTH-1:0] uint_i;
   logic [COORD_WIDTH-1:0]              col_i;
   logic [COORD_WIDTH-1:0]              row_i;
   logic                                valid_i;
   logic                                ready_o;
   logic [CHANNELS-1:0][FP_WIDTH-1:0]   fp_o;
   logic [COORD_WIDTH-1:0]              col_o;
   logic [COORD_WIDTH-1:0]              row_o;
   logic                                valid_o;
   logic                                ready_i;
   logic                                sof_o;
   logic                                eof_o;

   modport slave (
      input  uint_i, col_i, row_i, valid_i, ready_i,
      output ready_o, fp_o, col_o, row_o, valid_o, sof_o, eof_o
   );

   modport master (
      output uint_i, col_i, row_i, valid_i, ready_i,
      input  ready_o, fp_o, col_o, row_o, valid_o, sof_o, eof_o
   );
endinterface

// File: rtl/uint_fp_stream_converter_n.sv
// -----------------------------------------------------------------------------
// uint_fp_stream_converter_n
// Converts CHANNELS lock-step unsigned pixel streams to a sign/exponent/
// fraction floating-point format (bias 2^(EXP_WIDTH-1)-1, round to nearest
// even), carrying col/row at matched latency. Two register stages with
// ready/valid backpressure; a stalled output holds the whole pipeline.
// Also checks the incoming raster order and counts delivered frames.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-low
//   bus            stream bundle (slave modport), see the interface file
//   coord_err_o    sticky: an accepted input coordinate was out of sequence
//   frame_count_o  number of eof beats accepted downstream, wraps at 2^16
// -----------------------------------------------------------------------------
module uint_fp_stream_converter_n #(
   parameter int CHANNELS     = 2,
   parameter int UINT_WIDTH   = 8,
   parameter int EXP_WIDTH    = 5,
   parameter int FRAC_WIDTH   = 10,
   parameter int IMAGE_WIDTH  = 512,
   parameter int IMAGE_HEIGHT = 400,
   parameter int COORD_WIDTH  = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   uint_fp_stream_converter_n_if.slave       bus,
   output logic                              coord_err_o,
   output logic [15:0]                       frame_count_o
);
   localparam int FP_WIDTH   = 1 + EXP_WIDTH + FRAC_WIDTH;
   localparam int LZ_WIDTH   = $clog2(UINT_WIDTH + 1);
   localparam int BIAS       = (1 << (EXP_WIDTH - 1)) - 1;
   localparam int TAIL_WIDTH = UINT_WIDTH + FRAC_WIDTH;

   typedef logic [UINT_WIDTH-1:0] uint_t;
   typedef logic [LZ_WIDTH-1:0]   lz_t;
   typedef logic [FP_WIDTH-1:0]   fp_t;

   // Leading-zero count; a zero input reports UINT_WIDTH.
   function automatic lz_t lzc_f(input uint_t x);
      lz_t lz;
      lz = LZ_WIDTH'(UINT_WIDTH);
      for (int i = 0; i < UINT_WIDTH; i++) begin
         if (x[i]) lz = LZ_WIDTH'(UINT_WIDTH - 1 - i);
      end
      return lz;
   endfunction

   // Round to nearest even; the extra top bit is the mantissa carry.
   function automatic logic [FRAC_WIDTH:0] rne_f(input logic [FRAC_WIDTH-1:0] frac,
                                                 input logic guard,
                                                 input logic sticky);
      logic up;
      up = guard & (sticky | frac[0]);
      return {1'b0, frac} + {{FRAC_WIDTH{1'b0}}, up};
   endfunction

   // Normalise with the stage-1 count, drop the hidden bit, round and pack.
   // The tail is zero-padded so that short inputs simply left-align and
   // produce guard = sticky = 0.
   function automatic fp_t pack_f(input uint_t x, input lz_t lz);
      uint_t                   norm;
      logic [TAIL_WIDTH-1:0]   tail;
      logic [FRAC_WIDTH:0]     rnd;
      logic [EXP_WIDTH-1:0]    e;
      norm = x << lz;
      tail = {norm[UINT_WIDTH-2:0], {(FRAC_WIDTH + 1){1'b0}}};
      rnd  = rne_f(tail[TAIL_WIDTH-1 -: FRAC_WIDTH], tail[UINT_WIDTH-1],
                   |tail[UINT_WIDTH-2:0]);
      e    = EXP_WIDTH'(BIAS + UINT_WIDTH - 1 - int'(lz) + int'(rnd[FRAC_WIDTH]));
      if (x == '0) return '0;
      return {1'b0, e, rnd[FRAC_WIDTH-1:0]};
   endfunction

   logic en, accept;

   logic [CHANNELS-1:0][LZ_WIDTH-1:0]   lz_d;
   logic                                sof_d, eof_d;
   logic [CHANNELS-1:0][UINT_WIDTH-1:0] uint_p1_q;
   logic [CHANNELS-1:0][LZ_WIDTH-1:0]   lz_p1_q;
   logic [COORD_WIDTH-1:0]              col_p1_q, row_p1_q;
   logic                                sof_p1_q, eof_p1_q, vld_p1_q;

   logic [CHANNELS-1:0][FP_WIDTH-1:0]   fp_d;
   logic [CHANNELS-1:0][FP_WIDTH-1:0]   fp_p2_q;
   logic [COORD_WIDTH-1:0]              col_p2_q, row_p2_q;
   logic                                sof_p2_q, eof_p2_q, vld_p2_q;

   logic [COORD_WIDTH-1:0]              ec_d, ec_q, er_d, er_q;
   logic                                err_d, err_q;
   logic [15:0]                         frame_count_d, frame_count_q;

   assign en          = ~vld_p2_q | bus.ready_i;
   assign bus.ready_o = en & rst_i;
   assign accept      = bus.valid_i & bus.ready_o;

   // ---- stage 1: capture input, leading-zero count, frame-position flags ----
   always_comb begin
      lz_d = '0;
      for (int ch = 0; ch < CHANNELS; ch++) lz_d[ch] = lzc_f(bus.uint_i[ch]);
      sof_d = accept && (bus.col_i == '0) && (bus.row_i == '0);
      eof_d = accept && (bus.col_i == COORD_WIDTH'(IMAGE_WIDTH - 1))
                     && (bus.row_i == COORD_WIDTH'(IMAGE_HEIGHT - 1));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         vld_p1_q <= 1'b0;
         sof_p1_q <= 1'b0;
         eof_p1_q <= 1'b0;
      end else if (en) begin
         vld_p1_q <= accept;
         sof_p1_q <= sof_d;
         eof_p1_q <= eof_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         uint_p1_q <= bus.uint_i;
         lz_p1_q   <= lz_d;
         col_p1_q  <= bus.col_i;
         row_p1_q  <= bus.row_i;
      end
   end

   // ---- stage 2: normalise, round, pack; these registers drive the outputs ----
   always_comb begin
      fp_d = '0;
      for (int ch = 0; ch < CHANNELS; ch++) fp_d[ch] = pack_f(uint_p1_q[ch], lz_p1_q[ch]);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         vld_p2_q <= 1'b0;
         sof_p2_q <= 1'b0;
         eof_p2_q <= 1'b0;
         fp_p2_q  <= '0;
         col_p2_q <= '0;
         row_p2_q <= '0;
      end else if (en) begin
         vld_p2_q <= vld_p1_q;
         sof_p2_q <= sof_p1_q;
         eof_p2_q <= eof_p1_q;
         fp_p2_q  <= fp_d;
         col_p2_q <= col_p1_q;
         row_p2_q <= row_p1_q;
      end
   end

   assign bus.fp_o    = fp_p2_q;
   assign bus.col_o   = col_p2_q;
   assign bus.row_o   = row_p2_q;
   assign bus.valid_o = vld_p2_q;
   assign bus.sof_o   = sof_p2_q;
   assign bus.eof_o   = eof_p2_q;

   // Coordinate checker: the next expectation follows the received
   // coordinate, so a single glitch is flagged once and then resynchronised.
   always_comb begin
      ec_d  = ec_q;
      er_d  = er_q;
      err_d = err_q;
      if (accept) begin
         if ((bus.col_i != ec_q) || (bus.row_i != er_q)) err_d = 1'b1;
         if (bus.col_i == COORD_WIDTH'(IMAGE_WIDTH - 1)) begin
            ec_d = '0;
            er_d = (bus.row_i == COORD_WIDTH'(IMAGE_HEIGHT - 1)) ? '0
                   : bus.row_i + COORD_WIDTH'(1);
         end else begin
            ec_d = bus.col_i + COORD_WIDTH'(1);
            er_d = bus.row_i;
         end
      end
   end

   always_comb begin
      frame_count_d = frame_count_q;
      if (vld_p2_q && bus.ready_i && eof_p2_q) frame_count_d = frame_count_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ec_q          <= '0;
         er_q          <= '0;
         err_q         <= 1'b0;
         frame_count_q <= '0;
      end else begin
         ec_q          <= ec_d;
         er_q          <= er_d;
         err_q         <= err_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign coord_err_o   = err_q;
   assign frame_count_o = frame_count_q;
endmodule

// File: tb/tb_uint_fp_stream_converter_n.sv
// -----------------------------------------------------------------------------
// tb_uint_fp_stream_converter_n
// Directed bench for the uint -> fp stream converter. A small 128x12 raster
// keeps frames short. A reference model (log2 / integer-division rounding)
// predicts every output beat, the sticky coordinate flag and the frame
// counter; literal expectations pin conversion values, latency and flags.
// A second instance with 12-bit inputs covers the rounding cases.
// -----------------------------------------------------------------------------
module tb_uint_fp_stream_converter_n;
   localparam int W = 128;
   localparam int H = 12;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uint_fp_stream_converter_n_if #(.CHANNELS(2), .UINT_WIDTH(8),  .FP_WIDTH(16), .COORD_WIDTH(16)) bus_a ();
   uint_fp_stream_converter_n_if #(.CHANNELS(2), .UINT_WIDTH(12), .FP_WIDTH(16), .COORD_WIDTH(16)) bus_b ();

   logic        coord_err_a, coord_err_b;
   logic [15:0] frame_count_a, frame_count_b;

   uint_fp_stream_converter_n #(
      .CHANNELS(2), .UINT_WIDTH(8), .EXP_WIDTH(5), .FRAC_WIDTH(10),
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .COORD_WIDTH(16)
   ) u_dut (
      .clk_i(clk), .rst_i(rst_n), .bus(bus_a),
      .coord_err_o(coord_err_a), .frame_count_o(frame_count_a)
   );

   uint_fp_stream_converter_n #(
      .CHANNELS(2), .UINT_WIDTH(12), .EXP_WIDTH(5), .FRAC_WIDTH(10),
      .IMAGE_WIDTH(4), .IMAGE_HEIGHT(1), .COORD_WIDTH(16)
   ) u_dut12 (
      .clk_i(clk), .rst_i(rst_n), .bus(bus_b),
      .coord_err_o(coord_err_b), .frame_count_o(frame_count_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference conversion for 16-bit half precision from first principles.
   function automatic logic [15:0] ref_fp(input int n);
      longint num, q, r, unit;
      int e;
      if (n == 0) return 16'h0000;
      e = 0;
      while ((1 << (e + 1)) <= n) e++;
      unit = longint'(1) << e;
      num  = longint'(n - (1 << e)) << 10;
      q    = num >> e;
      r    = num - (q << e);
      if ((2 * r > unit) || ((2 * r == unit) && q[0])) q++;
      if (q == 1024) begin
         q = 0;
         e++;
      end
      return 16'((15 + e) * 1024 + q);
   endfunction

   typedef struct {
      logic [15:0] fp0;
      logic [15:0] fp1;
      int          col;
      int          row;
      bit          sof;
      bit          eof;
   } beat_t;

   beat_t exp_q[$];
   beat_t h, b;
   bit    err_m = 0;
   int    ec_m = 0, er_m = 0, fc_m = 0;
   bit    rst_low_prev = 0;
   bit    rand_ready = 0;

   // Model and compare, evaluated between edges.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("ready_o_in_reset", 96'(bus_a.ready_o), 96'(0));
         if (rst_low_prev) begin
            chk("valid_o_in_reset", 96'(bus_a.valid_o), 96'(0));
            chk("coord_err_in_reset", 96'(coord_err_a), 96'(0));
            chk("frame_count_in_reset", 96'(frame_count_a), 96'(0));
         end
         exp_q.delete();
         err_m = 0; ec_m = 0; er_m = 0; fc_m = 0;
         rst_low_prev = 1;
      end else begin
         rst_low_prev = 0;
         chk("coord_err", 96'(coord_err_a), 96'(err_m));
         chk("frame_count", 96'(frame_count_a), 96'(fc_m));
         if (bus_a.valid_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 96'(1), 96'(0));
            end else begin
               h = exp_q[0];
               chk("beat", 96'({bus_a.fp_o[1], bus_a.fp_o[0], bus_a.col_o, bus_a.row_o, bus_a.sof_o, bus_a.eof_o}),
                           96'({h.fp1, h.fp0, 16'(h.col), 16'(h.row), h.sof, h.eof}));
               if (bus_a.ready_i) begin
                  if (h.eof) fc_m++;
                  void'(exp_q.pop_front());
               end
            end
         end
         if (bus_a.valid_i && bus_a.ready_o) begin
            b.fp0 = ref_fp(int'(bus_a.uint_i[0]));
            b.fp1 = ref_fp(int'(bus_a.uint_i[1]));
            b.col = int'(bus_a.col_i);
            b.row = int'(bus_a.row_i);
            b.sof = (b.col == 0) && (b.row == 0);
            b.eof = (b.col == W - 1) && (b.row == H - 1);
            exp_q.push_back(b);
            if ((b.col != ec_m) || (b.row != er_m)) err_m = 1;
            if (b.col == W - 1) begin
               ec_m = 0;
               er_m = (b.row == H - 1) ? 0 : b.row + 1;
            end else begin
               ec_m = b.col + 1;
               er_m = b.row;
            end
         end
      end
   end

   // Downstream ready: always 1, or a 50% random pattern.
   initial begin
      bus_a.ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus_a.ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_beat(input int c, input int r, input logic [7:0] u0, input logic [7:0] u1);
      bit ok;
      int n;
      bus_a.col_i     = 16'(c);
      bus_a.row_i     = 16'(r);
      bus_a.uint_i[0] = u0;
      bus_a.uint_i[1] = u1;
      bus_a.valid_i   = 1'b1;
      ok = 0;
      n  = 0;
      while (!ok && n < 1000) begin
         @(negedge clk);
         ok = bus_a.ready_o;
         @(posedge clk);
         n++;
      end
      #1;
      if (!ok) chk("send_timeout", 96'(0), 96'(1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus_a.valid_i = 1'b0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("drain", 96'(exp_q.size()), 96'(0));
   endtask

   task automatic run_frame(input int start, input int skip_r, input int skip_c,
                            input int stop_r, input int stop_c);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (r * W + c < start) continue;
            if (r == skip_r && c == skip_c) continue;
            if (r == skip_r && c == skip_c + 1) begin
               chk("err_before_skip", 96'(coord_err_a), 96'(0));
               send_beat(c, r, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
               chk("err_after_skip", 96'(coord_err_a), 96'(1));
            end else begin
               send_beat(c, r, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
            if (r == stop_r && c == stop_c) return;
         end
      end
   endtask

   initial begin
      logic [7:0]  sv[4];
      logic [15:0] fv[4];
      logic [11:0] vin[4];
      logic [15:0] vout[4];
      sv   = '{8'd0, 8'd1, 8'd128, 8'd255};
      fv   = '{16'h0000, 16'h3C00, 16'h5800, 16'h5BF8};
      vin  = '{12'd4095, 12'd2049, 12'd2050, 12'd2051};
      vout = '{16'h6C00, 16'h6800, 16'h6801, 16'h6802};

      rst_n = 1'b0;
      bus_a.valid_i = 1'b0; bus_a.col_i = '0; bus_a.row_i = '0; bus_a.uint_i = '0;
      bus_b.valid_i = 1'b0; bus_b.col_i = '0; bus_b.row_i = '0; bus_b.uint_i = '0;
      bus_b.ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid_o", 96'(bus_a.valid_o), 96'(0));
      chk("rst_fp_o", 96'(bus_a.fp_o), 96'(0));
      chk("rst_col_row", 96'({bus_a.col_o, bus_a.row_o}), 96'(0));
      chk("rst_sof_eof", 96'({bus_a.sof_o, bus_a.eof_o}), 96'(0));
      chk("rst_frame_count", 96'(frame_count_a), 96'(0));
      chk("rst_ready_o", 96'(bus_a.ready_o), 96'(0));
      rst_n = 1'b1;
      #1;
      chk("ready_after_reset", 96'(bus_a.ready_o), 96'(1));

      // Conversion sweep: output appears two edges after the beat is presented.
      for (int k = 0; k < 4; k++) begin
         bus_a.col_i = 16'(k); bus_a.row_i = '0;
         bus_a.uint_i[0] = sv[k]; bus_a.uint_i[1] = sv[k];
         bus_a.valid_i = 1'b1;
         @(posedge clk);
         #1;
         bus_a.valid_i = 1'b0;
         chk($sformatf("sweep_early_%0d", k), 96'(bus_a.valid_o), 96'(0));
         @(posedge clk);
         #1;
         chk($sformatf("sweep_lat_%0d", k), 96'(bus_a.valid_o), 96'(1));
         chk($sformatf("sweep_fp_%0d", k), 96'({bus_a.fp_o[1], bus_a.fp_o[0]}), 96'({fv[k], fv[k]}));
      end
      chk("sweep_sof", 96'(bus_a.sof_o), 96'(0));

      // Rest of frame 1 with ready_i held high.
      run_frame(4, -1, -1, -1, -1);
      drain();
      chk("frame1_count", 96'(frame_count_a), 96'(1));
      chk("frame1_err", 96'(coord_err_a), 96'(0));

      // Frame 2 under random backpressure.
      rand_ready = 1;
      run_frame(0, -1, -1, -1, -1);
      rand_ready = 0;
      drain();
      chk("frame2_count", 96'(frame_count_a), 96'(2));
      chk("frame2_err", 96'(coord_err_a), 96'(0));

      // Frame 3 skips column 5 of row 3.
      run_frame(0, 3, 5, -1, -1);
      drain();
      chk("frame3_err_sticky", 96'(coord_err_a), 96'(1));
      chk("frame3_count", 96'(frame_count_a), 96'(3));

      // Frame 4 interrupted at (100,10) by a 3-cycle reset.
      run_frame(0, -1, -1, 10, 100);
      bus_a.col_i = 16'd101;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_valid_o", 96'(bus_a.valid_o), 96'(0));
      chk("midrst_ready_o", 96'(bus_a.ready_o), 96'(0));
      rst_n = 1'b1;
      bus_a.valid_i = 1'b0;
      chk("midrst_frame_count", 96'(frame_count_a), 96'(0));
      chk("midrst_err", 96'(coord_err_a), 96'(0));
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_no_partial", 96'(bus_a.valid_o), 96'(0));
      run_frame(0, -1, -1, -1, -1);
      drain();
      chk("frame5_count", 96'(frame_count_a), 96'(1));
      chk("frame5_err", 96'(coord_err_a), 96'(0));

      // 12-bit variant: rounding with exponent carry and ties to even.
      for (int k = 0; k < 4; k++) begin
         bus_b.col_i = 16'(k); bus_b.row_i = '0;
         bus_b.uint_i[0] = vin[k]; bus_b.uint_i[1] = 12'd3;
         bus_b.valid_i = 1'b1;
         @(posedge clk);
         #1;
         bus_b.valid_i = 1'b0;
         @(posedge clk);
         #1;
         chk($sformatf("v12_valid_%0d", k), 96'(bus_b.valid_o), 96'(1));
         chk($sformatf("v12_fp0_%0d", k), 96'(bus_b.fp_o[0]), 96'(vout[k]));
         chk($sformatf("v12_fp1_%0d", k), 96'(bus_b.fp_o[1]), 96'(16'h4200));
      end
      chk("v12_eof", 96'(bus_b.eof_o), 96'(1));
      @(posedge clk);
      #1;
      chk("v12_frame_count", 96'(frame_count_b), 96'(1));
      chk("v12_err", 96'(coord_err_b), 96'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
